// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared encodings and widths for the sequential 8x8 multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SH0 = 2'b00;
    localparam logic [1:0] SH4 = 2'b01;
    localparam logic [1:0] SH8 = 2'b10;

    localparam int NIB_W  = 4;
    localparam int PROD_W = 16;

    // Cross terms (steps 1 and 2) both land at nibble weight 4.
    function automatic logic [1:0] shift_for_step(input logic [1:0] count);
        case (count)
            2'd0:    return SH0;
            2'd3:    return SH8;
            default: return SH4;
        endcase
    endfunction

endpackage

// File: rtl/left_shifter_8_to_16.sv
// rtl/left_shifter_8_to_16.sv - zero-extend an 8-bit value to 16 bits and shift left by 0, 4 or 8
import mult_pkg::*;

module left_shifter_8_to_16 (
    input  logic [7:0]        data,
    input  logic [1:0]        shift_ctrl,
    output logic [PROD_W-1:0] shifted
);

    always_comb begin
        shifted = '0;
        case (shift_ctrl)
            SH0:     shifted = {8'h00, data};
            SH4:     shifted = {4'h0, data, 4'h0};
            SH8:     shifted = {data, 8'h00};
            default: shifted = '0;
        endcase
    end

endmodule

// File: rtl/mult4x4.sv
// rtl/mult4x4.sv - combinational 4x4 unsigned nibble multiplier
import mult_pkg::*;

module mult4x4 (
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] p
);

    assign p = {{NIB_W{1'b0}}, a} * {{NIB_W{1'b0}}, b};

endmodule

// File: rtl/mult8x8_sequencer.sv
// rtl/mult8x8_sequencer.sv - four-step nibble multiply-accumulate with start/busy/done handshake
import mult_pkg::*;

module mult8x8_sequencer #(
    parameter int unsigned ZERO_SKIP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        dataa,
    input  logic [7:0]        datab,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product,
    output logic [1:0]        shift_ctrl,
    output logic [1:0]        step
);

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         a_reg;
    logic [7:0]         b_reg;
    logic [1:0]         count;
    logic               skip_reg;
    logic [PROD_W-1:0]  acc;
    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [2*NIB_W-1:0] nib_prod;
    logic [PROD_W-1:0]  shifted;
    logic [PROD_W:0]    sum_full;
    logic               zero_hit;

    assign zero_hit = (ZERO_SKIP != 0) && ((dataa == 8'd0) || (datab == 8'd0));

    always_comb begin
        nib_a = a_reg[3:0];
        nib_b = b_reg[3:0];
        case (count)
            2'd0: begin nib_a = a_reg[3:0]; nib_b = b_reg[3:0]; end
            2'd1: begin nib_a = a_reg[7:4]; nib_b = b_reg[3:0]; end
            2'd2: begin nib_a = a_reg[3:0]; nib_b = b_reg[7:4]; end
            default: begin nib_a = a_reg[7:4]; nib_b = b_reg[7:4]; end
        endcase
    end

    mult4x4 u_mult4x4 (
        .a (nib_a),
        .b (nib_b),
        .p (nib_prod)
    );

    left_shifter_8_to_16 u_shifter (
        .data       (nib_prod),
        .shift_ctrl (shift_ctrl),
        .shifted    (shifted)
    );

    assign sum_full   = {1'b0, acc} + {1'b0, shifted};
    assign shift_ctrl = (state == CALC) ? shift_for_step(count) : SH0;
    assign step       = (state == CALC) ? count : 2'd0;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (skip_reg || count == 2'd3) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            count    <= '0;
            skip_reg <= 1'b0;
            acc      <= '0;
            product  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg    <= dataa;
                        b_reg    <= datab;
                        skip_reg <= zero_hit;
                        count    <= '0;
                        acc      <= '0;
                        product  <= '0;
                    end
                end
                CALC: begin
                    acc   <= sum_full[PROD_W-1:0];
                    count <= count + 2'd1;
                    // A skipped zero operand finishes after one calc cycle with a forced zero.
                    if (skip_reg) begin
                        product <= '0;
                    end else if (count == 2'd3) begin
                        product <= sum_full[PROD_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // 255*255 fits in 16 bits, so the adder can never carry out.
    always_ff @(posedge clk) begin
        if (rst_n && state == CALC) begin
            assert (!sum_full[PROD_W]);
        end
    end

endmodule

// File: tb/tb_mult8x8_sequencer.sv
// tb/tb_mult8x8_sequencer.sv - directed self-checking bench for mult8x8_sequencer
module tb_mult8x8_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;

    logic        u0_busy, u0_done;
    logic [15:0] u0_product;
    logic [1:0]  u0_shift, u0_step;
    logic        u1_busy, u1_done;
    logic [15:0] u1_product;
    logic [1:0]  u1_shift, u1_step;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult8x8_sequencer #(.ZERO_SKIP(0)) u0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dataa      (dataa),
        .datab      (datab),
        .busy       (u0_busy),
        .done       (u0_done),
        .product    (u0_product),
        .shift_ctrl (u0_shift),
        .step       (u0_step)
    );

    mult8x8_sequencer #(.ZERO_SKIP(1)) u1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dataa      (dataa),
        .datab      (datab),
        .busy       (u1_busy),
        .done       (u1_done),
        .product    (u1_product),
        .shift_ctrl (u1_shift),
        .step       (u1_step)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  exp_sh  [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
    logic [15:0] exp_acc [4] = '{16'h0008, 16'h0048, 16'h00A8, 16'h03A8};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        dataa = 8'h00;
        datab = 8'h00;
        tick();
        tick();
        chk("rst_busy",    16'(u0_busy), 16'd0);
        chk("rst_done",    16'(u0_done), 16'd0);
        chk("rst_product", u0_product,   16'h0000);
        chk("rst_shift",   16'(u0_shift), 16'd0);
        chk("rst_step",    16'(u0_step),  16'd0);
        rst_n = 1'b1;
        tick();

        // 0xFF * 0xFF
        dataa = 8'hFF; datab = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ff_shift%0d", i), 16'(u0_shift), 16'(exp_sh[i]));
            chk($sformatf("ff_step%0d", i),  16'(u0_step),  16'(i));
            chk($sformatf("ff_busy%0d", i),  16'(u0_busy),  16'd1);
            chk($sformatf("ff_done%0d", i),  16'(u0_done),  16'd0);
            tick();
        end
        chk("ff_done",    16'(u0_done), 16'd1);
        chk("ff_product", u0_product,   16'hFE01);
        tick();
        chk("ff_done_low", 16'(u0_done), 16'd0);
        chk("ff_busy_low", 16'(u0_busy), 16'd0);
        chk("ff_hold",     u0_product,   16'hFE01);

        // 0x12 * 0x34, accumulator after each step
        dataa = 8'h12; datab = 8'h34; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("acc_step%0d", i), u0.acc, exp_acc[i]);
        end
        chk("p1234_done",    16'(u0_done), 16'd1);
        chk("p1234_product", u0_product,   16'h03A8);
        tick();

        // 0xAB * 0xCD with start held and new operands during CALC
        dataa = 8'hAB; datab = 8'hCD; start = 1'b1;
        tick();
        dataa = 8'h01; datab = 8'h01;
        tick();
        tick();
        tick();
        chk("abcd_busy", 16'(u0_busy), 16'd1);
        tick();
        chk("abcd_done",    16'(u0_done), 16'd1);
        chk("abcd_product", u0_product,   16'h88EF);
        tick();
        chk("abcd_idle",  16'(u0_busy), 16'd0);
        chk("abcd_hold",  u0_product,   16'h88EF);
        tick();
        start = 1'b0;
        chk("one_busy",  16'(u0_busy), 16'd1);
        chk("one_clear", u0_product,   16'h0000);
        tick();
        tick();
        tick();
        tick();
        chk("one_done",    16'(u0_done), 16'd1);
        chk("one_product", u0_product,   16'h0001);
        tick();

        // zero operand, normal path on u0 and skip path on u1
        dataa = 8'h00; datab = 8'h7F; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zs_busy_n0",  16'(u1_busy),  16'd1);
        chk("zs_done_n0",  16'(u1_done),  16'd0);
        chk("zs_shift_n0", 16'(u1_shift), 16'd0);
        tick();
        chk("zs_done_n1",    16'(u1_done),  16'd1);
        chk("zs_product_n1", u1_product,    16'h0000);
        chk("zs_shift_n1",   16'(u1_shift), 16'd0);
        chk("z0_done_n1",    16'(u0_done),  16'd0);
        chk("z0_busy_n1",    16'(u0_busy),  16'd1);
        tick();
        chk("zs_done_n2", 16'(u1_done), 16'd0);
        chk("zs_busy_n2", 16'(u1_busy), 16'd0);
        tick();
        chk("z0_done_n3", 16'(u0_done), 16'd0);
        tick();
        chk("z0_done_n4",    16'(u0_done), 16'd1);
        chk("z0_product_n4", u0_product,   16'h0000);
        tick();

        // reset during count 2 of 0x55 * 0xAA
        dataa = 8'h55; datab = 8'hAA; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_step2", 16'(u0_step), 16'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy",    16'(u0_busy),  16'd0);
        chk("abort_done",    16'(u0_done),  16'd0);
        chk("abort_product", u0_product,    16'h0000);
        chk("abort_shift",   16'(u0_shift), 16'd0);
        chk("abort_step",    16'(u0_step),  16'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort_nodone%0d", i), 16'(u0_done), 16'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("p55aa_done",    16'(u0_done), 16'd1);
        chk("p55aa_product", u0_product,   16'h3872);
        tick();

        // product hold while idle with changing operands
        dataa = 8'h10; datab = 8'h10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("p1010_product", u0_product, 16'h0100);
        for (int i = 0; i < 10; i++) begin
            dataa = 8'($urandom_range(255));
            datab = 8'($urandom_range(255));
            tick();
            chk($sformatf("hold_product%0d", i), u0_product,   16'h0100);
            chk($sformatf("hold_done%0d", i),    16'(u0_done), 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
